// File: rtl/serial_comp.sv
// ---------------------------------------------------------------------------
// serial_comp
//
// Bit-serial one's / two's complement converter. A request on start captures
// the operand a together with the conversion select mode. The operand is then
// walked LSB first, one bit per clock. Each converted bit is presented on sout
// (qualified by sout_valid) and is also collected into a parallel result. When
// the last bit has been processed, the parallel result is published on b, ovf
// is updated and done pulses for one cycle.
//
// Parameters
//   WIDTH       operand width in bits (2..16)
//
// Ports
//   clk         clock; all state updates on its rising edge
//   rst_n       synchronous active-low reset
//   start       conversion request, only looked at while idle
//   a           operand, captured on the accepting edge
//   mode        0 = one's complement, 1 = two's complement, captured with a
//   busy        high while a conversion is shifting or completing
//   sout        serial result bit, LSB first (holds while sout_valid is low)
//   sout_valid  high for exactly WIDTH cycles, one per result bit
//   b           parallel result of the most recent completed conversion
//   done        one-cycle pulse marking a newly valid b
//   ovf         two's complement overflow (operand was the most negative value)
// ---------------------------------------------------------------------------
module serial_comp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic             mode,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] b,
  output logic             done,
  output logic             ovf
);

  // Counter only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic             r_seen_one;
  logic             r_busy;
  logic             r_sout;
  logic             r_sout_valid;
  logic [WIDTH-1:0] r_b;
  logic             r_done;
  logic             r_ovf;

  logic             w_bit_in;
  logic             w_bit_out;
  logic             w_last;
  logic [WIDTH-1:0] w_result;

  // Two's complement by the classic serial rule: copy bits up to and
  // including the first 1, invert every bit after it.
  assign w_bit_in  = r_sr[0];
  assign w_bit_out = r_mode ? (r_seen_one ? ~w_bit_in : w_bit_in) : ~w_bit_in;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // New bits enter from the MSB side so that after WIDTH shifts the bit
  // processed first ends up at position 0.
  assign w_result  = {w_bit_out, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_mode       <= 1'b0;
      r_seen_one   <= 1'b0;
      r_busy       <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_b          <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_sout_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr       <= a;
            r_mode     <= mode;
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_acc      <= '0;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end

        SHIFT: begin
          r_sout       <= w_bit_out;
          r_sout_valid <= 1'b1;
          if (r_mode) begin
            r_seen_one <= r_seen_one | w_bit_in;
          end
          r_sr  <= r_sr >> 1;
          r_cnt <= r_cnt + CW'(1);
          r_acc <= w_result;

          if (w_last) begin
            r_b     <= w_result;
            // The only operand whose negation keeps the sign bit set is
            // 1000..0: its input MSB and output MSB are both 1.
            r_ovf   <= r_mode & w_bit_in & w_bit_out;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here.
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign b          = r_b;
  assign done       = r_done;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_serial_comp.sv
// ---------------------------------------------------------------------------
// tb_serial_comp
//
// Directed and randomized checks of serial_comp against an arithmetic
// reference: mode 0 gives ~a, mode 1 gives (-a) mod 2^W, ovf only for
// mode 1 with a = 100..0. Outputs are sampled 1 time unit after each rising
// edge; inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_serial_comp;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic         mode;
  logic         busy;
  logic         sout;
  logic         sout_valid;
  logic [W-1:0] b;
  logic         done;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] last_b;
  logic         last_ovf;

  serial_comp #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .mode       (mode),
    .busy       (busy),
    .sout       (sout),
    .sout_valid (sout_valid),
    .b          (b),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_b(input logic [W-1:0] av, input logic m);
    int v;
    if (m) v = ((1 << W) - int'(av)) % (1 << W);
    else   v = (1 << W) - 1 - int'(av);
    return v[W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] av, input logic m);
    return m && (int'(av) == (1 << (W - 1)));
  endfunction

  // One complete conversion starting from IDLE. noisy scrambles start/a/mode
  // while busy; inject >= 0 re-pulses start with a = all ones in that SHIFT
  // cycle. Ends one cycle after done, so the next call is accepted WIDTH+2
  // edges after this one.
  task automatic run_conv(input logic [W-1:0] av, input logic m,
                          input bit noisy, input int inject);
    logic [W-1:0] eb;
    logic         eo;
    eb = ref_b(av, m);
    eo = ref_ovf(av, m);

    a = av; mode = m; start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy",  busy,       1);
    check("accept_valid", sout_valid, 0);
    check("accept_done",  done,       0);
    check("accept_b_hold", b,         last_b);

    for (int i = 0; i < W; i++) begin
      if (noisy) begin
        start = 1'($urandom);
        a     = W'($urandom);
        mode  = 1'($urandom);
      end else if (i == inject) begin
        start = 1'b1;
        a     = '1;
      end else begin
        start = 1'b0;
      end
      tick();
      check($sformatf("sout_valid a=%0h m=%0d bit%0d", av, m, i), sout_valid, 1);
      check($sformatf("sout a=%0h m=%0d bit%0d", av, m, i), sout, eb[i]);
      if (i == W - 1) begin
        check($sformatf("done a=%0h m=%0d", av, m), done, 1);
        check($sformatf("b a=%0h m=%0d", av, m), b, eb);
        check($sformatf("ovf a=%0h m=%0d", av, m), ovf, eo);
        check("busy_in_done", busy, 1);
      end else begin
        check("early_done", done, 0);
        check("b_hold_shift", b, last_b);
      end
    end

    // A start seen during the DONE cycle must be dropped.
    start = noisy ? 1'($urandom) : 1'b0;
    if (noisy) a = W'($urandom);
    tick();
    start = 1'b0;
    check("after_done_pulse", done,       0);
    check("after_busy",       busy,       0);
    check("after_valid",      sout_valid, 0);
    check("sout_hold",        sout,       eb[W-1]);
    check("b_hold_idle",      b,          eb);
    check("ovf_hold_idle",    ovf,        eo);
    last_b   = eb;
    last_ovf = eo;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; mode = 1'b0;
    last_b = '0; last_ovf = 1'b0;

    tick();
    tick();
    check("rst_busy",  busy,       0);
    check("rst_sout",  sout,       0);
    check("rst_valid", sout_valid, 0);
    check("rst_b",     b,          0);
    check("rst_done",  done,       0);
    check("rst_ovf",   ovf,        0);

    // Reset wins over a simultaneous start.
    start = 1'b1; a = 4'b0101; mode = 1'b1;
    tick();
    check("rst_vs_start_busy", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;

    // Worked examples and boundary operands.
    run_conv(4'b0101, 1'b1, 1'b0, -1);
    run_conv(4'b0101, 1'b0, 1'b0, -1);
    run_conv(4'b0000, 1'b1, 1'b0, -1);
    run_conv(4'b1000, 1'b1, 1'b0, -1);
    run_conv(4'b1111, 1'b1, 1'b0, -1);

    // Restart attempt during the second SHIFT cycle is ignored.
    run_conv(4'b0101, 1'b1, 1'b0, 1);

    // Reset during the third SHIFT cycle aborts the conversion.
    a = 4'b0101; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_busy",  busy,       0);
    check("abort_done",  done,       0);
    check("abort_b",     b,          0);
    check("abort_ovf",   ovf,        0);
    check("abort_valid", sout_valid, 0);
    check("abort_sout",  sout,       0);
    last_b = '0; last_ovf = 1'b0;
    rst_n = 1'b1;

    // Accepted on the first edge after reset release.
    run_conv(4'b0011, 1'b1, 1'b0, -1);

    // Full sweep, back to back.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < (1 << W); v++) begin
        run_conv(W'(v), 1'(m), 1'b0, -1);
      end
    end

    // Random operands with input noise while busy.
    for (int k = 0; k < 40; k++) begin
      run_conv(W'($urandom), 1'($urandom), 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
